seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 8-digit seven-segment scan bus (digit-select plus segment lines) that the stopwatch drives.
- Samples the scan lines, filters glitches, and decodes each segment pattern back to a BCD digit, storing it per digit position.
- Flags a completed scan frame.
- Used for self-checking display loopback on the board and as a capture front-end when one board reads another board's display bus.

Parameters:
- DIGITS, 8: number of scanned positions, 1..8; positions 0..DIGITS-1 are legal.
- STABLE_CYC, 4: consecutive identical samples required before a pattern is accepted, 2..255.
- BIT_ACTIVE_LOW, 1: 1 = digit-select lines are active-low.
- SEG_ACTIVE_LOW, 0: 1 = segment lines are active-low.

Ports:
- clk, input, 1: single system clock; everything is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- led_bit, input, 8: digit-select lines from the scan bus; asynchronous to clk.
- led_seg, input, 8: segment lines {dp,g,f,e,d,c,b,a}; asynchronous to clk.
- digit_val, output, 32: nibble i = [4i+3:4i] = decoded value of position i (0-9, or F = blank).
- dp_val, output, 8: decimal-point state per position.
- digit_valid, output, 8: position i holds a legal decoded glyph.
- frame_done, output, 1: one-cycle pulse when every position 0..DIGITS-1 has been captured since the last pulse.
- bit_err, output, 1: one-cycle pulse when an accepted select pattern is not legal.
- glyph_err, output, 1: one-cycle pulse when an accepted segment pattern is not a legal glyph.

Behaviour:
- Interface decisions:
  - One clock (clk).
  - Reset is asynchronous and active-high (reset). All registers clear immediately on assertion; the block resumes on the first clk edge after release.
- Reset values:
  - digit_val = 0, dp_val = 0, digit_valid = 0.
  - frame_done = 0, bit_err = 0, glyph_err = 0.
  - Internal seen mask = 0, stability counter = 0.
  - Sync registers = normalized-inactive (all zero after polarity normalization).
- Input path:
  - Two-flop synchronizer on all 16 lines.
  - Normalize polarity: bsel = led_bit XOR {8{BIT_ACTIVE_LOW}}; seg = led_seg XOR {8{SEG_ACTIVE_LOW}}.
- Stability filter:
  - prev register holds the last {bsel,seg}.
  - If the new sample equals prev, cnt increments, saturating at STABLE_CYC. Otherwise cnt = 0.
  - An accept event fires exactly once per stable run, on the cycle cnt reaches STABLE_CYC-1, i.e. after STABLE_CYC identical samples. A held pattern never re-fires.
- Latency: registered outputs reflect a clean pin change after edge STABLE_CYC+3, counting the first edge that samples the new pins as edge 1. Fixed; the bench checks it exactly.
- On accept, evaluated in priority order:
  1. bsel == 0 (inter-digit blanking): ignored, no pulse.
  2. bsel not one-hot, or a set bit at index >= DIGITS: bit_err pulses; no storage.
  3. Otherwise let i = the set bit. Decode seg[6:0] as hex:
     - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 00→F (blank).
     - Legal: digit_val[i] = code, dp_val[i] = seg[7], digit_valid[i] = 1.
     - Illegal: digit_valid[i] = 0, digit_val[i] unchanged, dp_val[i] = seg[7], glyph_err pulses.
     - In both cases seen[i] = 1.
- Frame tracking:
  - When the accept sets the last missing bit of seen[DIGITS-1:0], frame_done pulses on the following cycle and seen clears in that same cycle.
  - An accept landing on the frame_done cycle is recorded into the freshly cleared mask; it is not lost.
  - Repeated captures of one position within a frame are allowed and overwrite.
- Pulses: bit_err, glyph_err and frame_done are registered and high for exactly one cycle per event. They never stretch.
- Reset mid-frame: partial seen is discarded and outputs return to reset values. The first full frame after release produces frame_done.
- Inputs are assumed glitch-free only after filtering. Chatter shorter than STABLE_CYC samples must produce no accept.

Test Plan:
1. Reset, then a clean scan of positions 0..7 showing "12345678", each held 10 cycles with 3-cycle blanking between (STABLE_CYC=4, BIT_ACTIVE_LOW=1) -> digit_val = 32'h87654321, digit_valid = FF, frame_done exactly one pulse; output timing exactly STABLE_CYC+3 edges after the pin change.
2. Position 2 with seg = 8'hBF (0 with dp) -> digit_val[11:8] = 0, dp_val[2] = 1, no errors.
3. led_bit = 8'b1111_0011 (two active-low selects) held 6 cycles -> bit_err one pulse, no storage change, no frame_done; with DIGITS=5, select of position 6 -> bit_err.
4. seg = 8'h49 on position 4 -> glyph_err one pulse, digit_valid[4] = 0, digit_val[19:16] retains previous value; the frame still completes.
5. Toggle segment lines every 2 cycles on position 1 for 20 cycles, then hold 3F -> no accepts during toggling, then digit_val[7:4] = 0 once.
6. Assert reset after 5 of 8 positions, release, then scan all 8 -> outputs zero during reset; exactly one frame_done after the 8th position, none earlier.

Source files
------------

// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//
// Receive side of a multiplexed seven-segment scan bus. The digit-select and
// segment lines are synchronized, polarity-normalized, glitch-filtered, and
// every stable {select, segment} pattern is decoded back into a BCD digit
// stored against its scan position. A pulse marks each completed scan frame.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   asynchronous active-high reset
//   led_bit[7:0] in   digit-select lines (asynchronous to clk)
//   led_seg[7:0] in   segment lines {dp,g,f,e,d,c,b,a} (asynchronous to clk)
//   digit_val    out  nibble i = decoded value of position i (0-9, F = blank)
//   dp_val       out  decimal-point state per position
//   digit_valid  out  position i holds a legal decoded glyph
//   frame_done   out  one-cycle pulse, every position captured since last pulse
//   bit_err      out  one-cycle pulse, accepted select pattern not legal
//   glyph_err    out  one-cycle pulse, accepted segment pattern not a glyph
//
// Pipeline from a pin change (edge 1 = first edge that samples new pins):
//   edge 1..2        two-flop synchronizer
//   edge 3           filter sees the new pattern, run counter restarts at 0
//   edge STABLE_CYC+2  counter reaches STABLE_CYC-1 -> accept strobe registered
//   edge STABLE_CYC+3  decoded result lands in the output registers
// -----------------------------------------------------------------------------
module seg_scan_capture #(
  parameter int DIGITS         = 8,
  parameter int STABLE_CYC     = 4,
  parameter int BIT_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  led_bit,
  input  logic [7:0]  led_seg,
  output logic [31:0] digit_val,
  output logic [7:0]  dp_val,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        bit_err,
  output logic        glyph_err
);

  localparam logic [7:0] BIT_INV    = (BIT_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  // Positions 0..DIGITS-1 are the only legal select bits.
  localparam logic [7:0] LEGAL_MASK = 8'hFF >> (8 - DIGITS);
  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_FIRE   = 8'(STABLE_CYC - 2);

  // ---------------------------------------------------------------------------
  // Input synchronizer. Polarity is normalized ahead of the flops (XOR with a
  // constant), so the reset value of zero is the inactive bus state.
  // ---------------------------------------------------------------------------
  logic [15:0] pins_norm;
  logic [15:0] sync1;
  logic [15:0] sync2;

  assign pins_norm = {led_bit ^ BIT_INV, led_seg ^ SEG_INV};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_norm;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability filter. cnt counts repeats of prev and saturates at STABLE_CYC,
  // so the accept strobe fires only on the single transition into
  // STABLE_CYC-1; a held pattern never fires again.
  // ---------------------------------------------------------------------------
  logic [15:0] prev;
  logic [7:0]  cnt;
  logic        same;
  logic        acc_stb;
  logic [15:0] acc_pat;

  assign same = (sync2 == prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      cnt     <= '0;
      acc_stb <= 1'b0;
      acc_pat <= '0;
    end else begin
      prev    <= sync2;
      acc_pat <= sync2;
      acc_stb <= same && (cnt == CNT_FIRE);
      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-pattern classification
  // ---------------------------------------------------------------------------
  logic [7:0] acc_bsel;
  logic [7:0] acc_seg;
  logic       sel_blank;
  logic       sel_onehot;
  logic       sel_in_range;
  logic       sel_ok;
  logic [2:0] sel_idx;
  logic       g_legal;
  logic [3:0] g_code;

  assign acc_bsel = acc_pat[15:8];
  assign acc_seg  = acc_pat[7:0];

  // Returns {legal, code}; all-segments-off is the blank glyph, coded F.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h00:   return {1'b1, 4'hF};
      default: return {1'b0, 4'h0};
    endcase
  endfunction

  always_comb begin
    sel_blank    = (acc_bsel == 8'h00);
    sel_onehot   = ((acc_bsel & (acc_bsel - 8'd1)) == 8'h00);
    sel_in_range = ((acc_bsel & ~LEGAL_MASK) == 8'h00);
    sel_ok       = sel_onehot && sel_in_range;
    sel_idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (acc_bsel[i]) begin
        sel_idx = 3'(i);
      end
    end
    {g_legal, g_code} = decode_glyph(acc_seg[6:0]);
  end

  // ---------------------------------------------------------------------------
  // Capture storage and frame tracking
  // ---------------------------------------------------------------------------
  logic [7:0]  seen;
  logic [7:0]  seen_n;
  logic [31:0] digit_val_n;
  logic [7:0]  dp_val_n;
  logic [7:0]  digit_valid_n;
  logic        frame_done_n;
  logic        bit_err_n;
  logic        glyph_err_n;

  always_comb begin
    digit_val_n   = digit_val;
    dp_val_n      = dp_val;
    digit_valid_n = digit_valid;
    seen_n        = seen;
    frame_done_n  = 1'b0;
    bit_err_n     = 1'b0;
    glyph_err_n   = 1'b0;
    // Blank (no select active) is the normal inter-digit gap: ignored.
    if (acc_stb && !sel_blank) begin
      if (!sel_ok) begin
        bit_err_n = 1'b1;
      end else begin
        dp_val_n[sel_idx] = acc_seg[7];
        if (g_legal) begin
          digit_val_n[{sel_idx, 2'b00} +: 4] = g_code;
          digit_valid_n[sel_idx]             = 1'b1;
        end else begin
          // Stored nibble is kept; only the valid flag drops.
          digit_valid_n[sel_idx] = 1'b0;
          glyph_err_n            = 1'b1;
        end
        // acc_bsel is one-hot here, so it is exactly the position bit.
        seen_n = seen | acc_bsel;
        // Clearing in the same update lets the next accept start a new frame.
        if ((seen_n & LEGAL_MASK) == LEGAL_MASK) begin
          frame_done_n = 1'b1;
          seen_n       = 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_val   <= '0;
      dp_val      <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      bit_err     <= 1'b0;
      glyph_err   <= 1'b0;
    end else begin
      digit_val   <= digit_val_n;
      dp_val      <= dp_val_n;
      digit_valid <= digit_valid_n;
      seen        <= seen_n;
      frame_done  <= frame_done_n;
      bit_err     <= bit_err_n;
      glyph_err   <= glyph_err_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_capture
//
// Directed bench for seg_scan_capture. A second instance with DIGITS=5 shares
// the pins so out-of-range select detection can be observed. Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 time unit after a
// rising edge, and pulse outputs are counted on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_capture;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic [7:0] led_bit;
  logic [7:0] led_seg;

  always #5 clk = ~clk;

  logic [31:0] digit_val;
  logic [7:0]  dp_val;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        bit_err;
  logic        glyph_err;

  logic [31:0] digit_val5;
  logic [7:0]  dp_val5;
  logic [7:0]  digit_valid5;
  logic        frame_done5;
  logic        bit_err5;
  logic        glyph_err5;

  seg_scan_capture #(
    .DIGITS(8), .STABLE_CYC(4), .BIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .led_bit(led_bit), .led_seg(led_seg),
    .digit_val(digit_val), .dp_val(dp_val), .digit_valid(digit_valid),
    .frame_done(frame_done), .bit_err(bit_err), .glyph_err(glyph_err)
  );

  seg_scan_capture #(
    .DIGITS(5), .STABLE_CYC(4), .BIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut5 (
    .clk(clk), .reset(reset), .led_bit(led_bit), .led_seg(led_seg),
    .digit_val(digit_val5), .dp_val(dp_val5), .digit_valid(digit_valid5),
    .frame_done(frame_done5), .bit_err(bit_err5), .glyph_err(glyph_err5)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int be_cnt = 0;
  int ge_cnt = 0;
  int be5_cnt = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (bit_err === 1'b1) be_cnt++;
    if (glyph_err === 1'b1) ge_cnt++;
    if (bit_err5 === 1'b1) be5_cnt++;
  end

  // Segment patterns for digits 0..9
  logic [7:0] seg_code [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic blank(input int n);
    led_bit = 8'hFF;
    led_seg = 8'h00;
    step(n);
  endtask

  // One scan slot: select held 10 cycles, then 3 cycles of blanking.
  task automatic scan_digit(input int pos, input logic [7:0] seg);
    led_bit = ~(8'h01 << pos);
    led_seg = seg;
    step(10);
    blank(3);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset   = 1'b1;
    led_bit = 8'hFF;
    led_seg = 8'h00;
    step(3);
    checks++;
    if (digit_val !== 32'h0) begin
      errors++; $display("FAIL reset_digit_val: got %h expected %h", digit_val, 32'h0);
    end
    checks++;
    if ({dp_val, digit_valid} !== 16'h0) begin
      errors++; $display("FAIL reset_dp_valid: got %h expected %h", {dp_val, digit_valid}, 16'h0);
    end
    checks++;
    if ({frame_done, bit_err, glyph_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected %b", {frame_done, bit_err, glyph_err}, 3'b000);
    end
    reset = 1'b0;
    step(5);
  endtask

  // Exact latency on position 0, then the rest of "12345678".
  task automatic test_clean_scan;
    int fd0;
    int err0;
    logic [3:0] nib;
    fd0  = fd_cnt;
    err0 = be_cnt + ge_cnt;
    led_bit = 8'hFE;
    led_seg = 8'h06;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      checks++;
      if (digit_valid[0] !== 1'b0) begin
        errors++; $display("FAIL latency_early_edge%0d: got %b expected %b", e, digit_valid[0], 1'b0);
      end
    end
    step(1);
    nib = digit_val[3:0];
    checks++;
    if ({digit_valid[0], nib} !== 5'h11) begin
      errors++; $display("FAIL latency_edge7: got %h expected %h", {digit_valid[0], nib}, 5'h11);
    end
    step(3);
    blank(3);
    for (int p = 1; p <= 6; p++) scan_digit(p, seg_code[p + 1]);
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      errors++; $display("FAIL frame_early: got %0d expected %0d", fd_cnt - fd0, 0);
    end
    scan_digit(7, seg_code[8]);
    checks++;
    if (digit_val !== 32'h87654321) begin
      errors++; $display("FAIL scan_digit_val: got %h expected %h", digit_val, 32'h87654321);
    end
    checks++;
    if (digit_valid !== 8'hFF) begin
      errors++; $display("FAIL scan_valid: got %h expected %h", digit_valid, 8'hFF);
    end
    checks++;
    if (dp_val !== 8'h00) begin
      errors++; $display("FAIL scan_dp: got %h expected %h", dp_val, 8'h00);
    end
    checks++;
    if (fd_cnt - fd0 !== 1) begin
      errors++; $display("FAIL scan_frame_done: got %0d expected %0d", fd_cnt - fd0, 1);
    end
    checks++;
    if (be_cnt + ge_cnt - err0 !== 0) begin
      errors++; $display("FAIL scan_errors: got %0d expected %0d", be_cnt + ge_cnt - err0, 0);
    end
  endtask

  task automatic test_dp;
    int err0;
    err0 = be_cnt + ge_cnt;
    scan_digit(2, 8'hBF);
    checks++;
    if (digit_val !== 32'h87654021) begin
      errors++; $display("FAIL dp_digit_val: got %h expected %h", digit_val, 32'h87654021);
    end
    checks++;
    if (dp_val !== 8'h04) begin
      errors++; $display("FAIL dp_val: got %h expected %h", dp_val, 8'h04);
    end
    checks++;
    if (be_cnt + ge_cnt - err0 !== 0) begin
      errors++; $display("FAIL dp_errors: got %0d expected %0d", be_cnt + ge_cnt - err0, 0);
    end
  endtask

  task automatic test_bad_select;
    int be0;
    int be50;
    int fd0;
    be0  = be_cnt;
    be50 = be5_cnt;
    fd0  = fd_cnt;
    led_bit = 8'b1111_0011;
    led_seg = 8'h06;
    step(6);
    blank(6);
    checks++;
    if (be_cnt - be0 !== 1) begin
      errors++; $display("FAIL two_select_bit_err: got %0d expected %0d", be_cnt - be0, 1);
    end
    checks++;
    if ({digit_val, digit_valid, dp_val} !== {32'h87654021, 8'hFF, 8'h04}) begin
      errors++; $display("FAIL two_select_storage: got %h expected %h",
                         {digit_val, digit_valid, dp_val}, {32'h87654021, 8'hFF, 8'h04});
    end
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      errors++; $display("FAIL two_select_frame: got %0d expected %0d", fd_cnt - fd0, 0);
    end
    // Position 6 is legal for the 8-digit instance, out of range for DIGITS=5.
    be0  = be_cnt;
    be50 = be5_cnt;
    scan_digit(6, seg_code[7]);
    checks++;
    if (be5_cnt - be50 !== 1) begin
      errors++; $display("FAIL range_bit_err_d5: got %0d expected %0d", be5_cnt - be50, 1);
    end
    checks++;
    if (be_cnt - be0 !== 0) begin
      errors++; $display("FAIL range_bit_err_d8: got %0d expected %0d", be_cnt - be0, 0);
    end
  endtask

  task automatic test_bad_glyph;
    int ge0;
    int fd0;
    logic [3:0] nib;
    ge0 = ge_cnt;
    fd0 = fd_cnt;
    scan_digit(4, 8'h49);
    nib = digit_val[19:16];
    checks++;
    if (ge_cnt - ge0 !== 1) begin
      errors++; $display("FAIL glyph_err_count: got %0d expected %0d", ge_cnt - ge0, 1);
    end
    checks++;
    if ({digit_valid[4], nib} !== 5'h05) begin
      errors++; $display("FAIL glyph_keep: got %h expected %h", {digit_valid[4], nib}, 5'h05);
    end
    scan_digit(0, seg_code[1]);
    scan_digit(1, seg_code[2]);
    scan_digit(3, seg_code[4]);
    scan_digit(5, seg_code[6]);
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      errors++; $display("FAIL glyph_frame_early: got %0d expected %0d", fd_cnt - fd0, 0);
    end
    scan_digit(7, seg_code[8]);
    checks++;
    if (fd_cnt - fd0 !== 1) begin
      errors++; $display("FAIL glyph_frame_done: got %0d expected %0d", fd_cnt - fd0, 1);
    end
    checks++;
    if ({digit_val, digit_valid} !== {32'h87654021, 8'hEF}) begin
      errors++; $display("FAIL glyph_frame_state: got %h expected %h",
                         {digit_val, digit_valid}, {32'h87654021, 8'hEF});
    end
  endtask

  task automatic test_chatter;
    int err0;
    logic [3:0] nib;
    err0 = be_cnt + ge_cnt;
    led_bit = 8'hFD;
    for (int k = 0; k < 10; k++) begin
      led_seg = (k % 2 == 0) ? 8'h06 : 8'h4F;
      step(2);
    end
    nib = digit_val[7:4];
    checks++;
    if (nib !== 4'h2) begin
      errors++; $display("FAIL chatter_no_accept: got %h expected %h", nib, 4'h2);
    end
    led_seg = 8'h3F;
    step(10);
    blank(3);
    nib = digit_val[7:4];
    checks++;
    if (nib !== 4'h0) begin
      errors++; $display("FAIL chatter_settle: got %h expected %h", nib, 4'h0);
    end
    checks++;
    if (be_cnt + ge_cnt - err0 !== 0) begin
      errors++; $display("FAIL chatter_errors: got %0d expected %0d", be_cnt + ge_cnt - err0, 0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int fd0;
    fd0 = fd_cnt;
    for (int p = 0; p < 5; p++) scan_digit(p, seg_code[p + 1]);
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      errors++; $display("FAIL midreset_partial: got %0d expected %0d", fd_cnt - fd0, 0);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({digit_val, dp_val, digit_valid} !== 48'h0) begin
      errors++; $display("FAIL midreset_async_clear: got %h expected %h",
                         {digit_val, dp_val, digit_valid}, 48'h0);
    end
    step(3);
    checks++;
    if ({digit_val, dp_val, digit_valid, frame_done, bit_err, glyph_err} !== 51'h0) begin
      errors++; $display("FAIL midreset_held: got %h expected %h",
                         {digit_val, dp_val, digit_valid, frame_done, bit_err, glyph_err}, 51'h0);
    end
    reset = 1'b0;
    step(4);
    fd0 = fd_cnt;
    for (int p = 0; p < 7; p++) scan_digit(p, seg_code[p + 1]);
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      errors++; $display("FAIL midreset_frame_early: got %0d expected %0d", fd_cnt - fd0, 0);
    end
    scan_digit(7, seg_code[8]);
    checks++;
    if (fd_cnt - fd0 !== 1) begin
      errors++; $display("FAIL midreset_frame_done: got %0d expected %0d", fd_cnt - fd0, 1);
    end
    checks++;
    if ({digit_val, digit_valid} !== {32'h87654321, 8'hFF}) begin
      errors++; $display("FAIL midreset_final: got %h expected %h",
                         {digit_val, digit_valid}, {32'h87654321, 8'hFF});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clean_scan();
    test_dp();
    test_bad_select();
    test_bad_glyph();
    test_chatter();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
